// File: rtl/tile_output_collector_if.sv
// Tile output collector bus: tile write ports,
// completion levels, host readback and status.
interface tile_output_collector_if #(
   parameter int DWIDTH       = 16,
   parameter int AWIDTH       = 7,
   parameter int MAT_MUL_SIZE = 4,
   parameter int NUM_TILES    = 4,
   parameter int TSEL         = 2
);
   localparam int RW = MAT_MUL_SIZE * DWIDTH;
   localparam int CW = AWIDTH + 1;

   logic                      start;
   logic [NUM_TILES-1:0]      tile_we;
   logic [NUM_TILES*AWIDTH-1:0] tile_addr;
   logic [NUM_TILES*RW-1:0]   tile_data;
   logic [NUM_TILES-1:0]      tile_done;
   logic                      rd_req;
   logic [TSEL-1:0]           rd_tile;
   logic [AWIDTH-1:0]         rd_addr;
   logic                      rd_valid;
   logic [RW-1:0]             rd_data;
   logic [NUM_TILES*CW-1:0]   wr_count;
   logic                      busy;
   logic                      done;
   logic                      err_rd_busy;

   modport master (
      output start, tile_we, tile_addr, tile_data,
      output tile_done, rd_req, rd_tile, rd_addr,
      input  rd_valid, rd_data, wr_count,
      input  busy, done, err_rd_busy
   );

   modport slave (
      input  start, tile_we, tile_addr, tile_data,
      input  tile_done, rd_req, rd_tile, rd_addr,
      output rd_valid, rd_data, wr_count,
      output busy, done, err_rd_busy
   );
endinterface

// File: rtl/tile_output_collector.sv
// Collects systolic tile result rows into private
// banks and serves host readback once a pass ends.
module tile_output_collector #(
   parameter int DWIDTH       = 16,
   parameter int AWIDTH       = 7,
   parameter int MAT_MUL_SIZE = 4,
   parameter int NUM_TILES    = 4,
   parameter int TSEL         = 2
) (
   input logic clk,
   input logic reset,
   tile_output_collector_if.slave bus
);
   localparam int RW    = MAT_MUL_SIZE * DWIDTH;
   localparam int CW    = AWIDTH + 1;
   localparam int DEPTH = 1 << AWIDTH;
   localparam logic [CW-1:0] CMAX = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_TILES-1:0]    flag_q, flag_d;
   logic [NUM_TILES*CW-1:0] cnt_q, cnt_d;
   logic                    err_q, err_d;

   logic                    rd_v1_q;
   logic [TSEL-1:0]         rd_sel_q;
   logic                    rd_valid_q;
   logic [RW-1:0]           rd_data_q;
   logic [RW-1:0]           rd_mux;
   logic [RW-1:0]           bank_out [NUM_TILES];

   logic                    run;
   logic                    clr;
   logic                    rd_acc;
   logic [NUM_TILES-1:0]    flag_all;

   assign run      = (state_q == RUN);
   assign clr      = !run && bus.start;
   assign rd_acc   = bus.rd_req && !run && !bus.start;
   assign flag_all = flag_q | bus.tile_done;

   // Pass sequencing, sticky done flags and the busy-read error
   always_comb begin
      state_d = state_q;
      flag_d  = flag_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               flag_d  = '0;
               err_d   = 1'b0;
            end
         end
         RUN: begin
            flag_d = flag_all;
            if (&flag_all && (bus.tile_we == '0)) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a rejected read lands after any start clear
      if (bus.rd_req && !rd_acc) begin
         err_d = 1'b1;
      end
   end

   // Per-tile write counters, saturating at the bank depth
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (clr) begin
            cnt_d[i*CW +: CW] = '0;
         end else if (run && bus.tile_we[i] &&
                      (cnt_q[i*CW +: CW] != CMAX)) begin
            cnt_d[i*CW +: CW] = cnt_q[i*CW +: CW] + CW'(1);
         end
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         flag_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   for (genvar g = 0; g < NUM_TILES; g++) begin : g_bank
      logic [RW-1:0] mem [DEPTH];
      logic [RW-1:0] rd_q;

      // Bank contents survive reset; read port registers on accept
      always_ff @(posedge clk) begin
         if (run && bus.tile_we[g]) begin
            mem[bus.tile_addr[g*AWIDTH +: AWIDTH]] <=
               bus.tile_data[g*RW +: RW];
         end
         if (rd_acc) begin
            rd_q <= mem[bus.rd_addr];
         end
      end

      assign bank_out[g] = rd_q;
   end

   // Registered bank select picks one bank; out of range gives zero
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_TILES; i++) begin
         if (rd_sel_q == TSEL'(i)) begin
            rd_mux = bank_out[i];
         end
      end
   end

   // Two-stage readback pipeline; data holds between pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_v1_q    <= 1'b0;
         rd_sel_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_v1_q    <= rd_acc;
         rd_valid_q <= rd_v1_q;
         if (rd_acc) begin
            rd_sel_q <= bus.rd_tile;
         end
         if (rd_v1_q) begin
            rd_data_q <= rd_mux;
         end
      end
   end

   assign bus.rd_valid    = rd_valid_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.wr_count    = cnt_q;
   assign bus.busy        = run;
   assign bus.done        = (state_q == DONE);
   assign bus.err_rd_busy = err_q;

endmodule

// File: tb/tb_tile_output_collector.sv
// Randomized scoreboard bench for the tile output
// collector against a behavioural pass/bank model.
module tb_tile_output_collector;
   localparam int DW = 16;
   localparam int AW = 7;
   localparam int MS = 4;
   localparam int NT = 4;
   localparam int TS = 2;
   localparam int RW = MS * DW;
   localparam int CW = AW + 1;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   tile_output_collector_if #(
      .DWIDTH(DW), .AWIDTH(AW), .MAT_MUL_SIZE(MS),
      .NUM_TILES(NT), .TSEL(TS)
   ) bus ();

   tile_output_collector #(
      .DWIDTH(DW), .AWIDTH(AW), .MAT_MUL_SIZE(MS),
      .NUM_TILES(NT), .TSEL(TS)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   tile_output_collector_if #(
      .DWIDTH(DW), .AWIDTH(AW), .MAT_MUL_SIZE(MS),
      .NUM_TILES(3), .TSEL(TS)
   ) bus3 ();

   tile_output_collector #(
      .DWIDTH(DW), .AWIDTH(AW), .MAT_MUL_SIZE(MS),
      .NUM_TILES(3), .TSEL(TS)
   ) dut3 (
      .clk(clk), .reset(reset), .bus(bus3)
   );

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural model: banks, pass flags, counts
   logic [RW-1:0] m_mem [NT][DEPTH];
   bit            m_run, m_done, m_err;
   bit [NT-1:0]   m_flags;
   int            m_cnt [NT];
   logic [RW-1:0] m_last;

   typedef struct {
      logic [RW-1:0] data;
      int            cyc;
   } rd_t;
   rd_t sb[$];

   task automatic chk(input string name,
                      input logic [RW-1:0] act,
                      input logic [RW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h",
                    name, act, exp);
   endtask

   function automatic logic [RW-1:0] rnd_row();
      return {$urandom, $urandom};
   endfunction

   task automatic idle();
      bus.start     = 1'b0;
      bus.tile_we   = '0;
      bus.tile_addr = '0;
      bus.tile_data = '0;
      bus.tile_done = '0;
      bus.rd_req    = 1'b0;
      bus.rd_tile   = '0;
      bus.rd_addr   = '0;
   endtask

   task automatic idle3();
      bus3.start     = 1'b0;
      bus3.tile_we   = '0;
      bus3.tile_addr = '0;
      bus3.tile_data = '0;
      bus3.tile_done = '0;
      bus3.rd_req    = 1'b0;
      bus3.rd_tile   = '0;
      bus3.rd_addr   = '0;
   endtask

   // apply the model to this cycle's inputs, clock, compare status
   task automatic tick();
      bit   was_run;
      bit   rej;
      rd_t  e;
      was_run = m_run;
      rej = 1'b0;
      if (bus.rd_req) begin
         if (!was_run && !bus.start) begin
            e.data = m_mem[bus.rd_tile][bus.rd_addr];
            e.cyc  = cyc + 2;
            sb.push_back(e);
         end else begin
            rej = 1'b1;
         end
      end
      if (!was_run && bus.start) begin
         m_run = 1'b1;
         m_done = 1'b0;
         m_flags = '0;
         m_err = 1'b0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (was_run) begin
         for (int i = 0; i < NT; i++) begin
            if (bus.tile_we[i]) begin
               m_mem[i][bus.tile_addr[i*AW +: AW]] =
                  bus.tile_data[i*RW +: RW];
               if (m_cnt[i] < DEPTH) m_cnt[i]++;
            end
         end
         m_flags |= bus.tile_done;
         if (&m_flags && bus.tile_we == '0) begin
            m_run = 1'b0;
            m_done = 1'b1;
         end
      end
      if (rej) m_err = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("busy", bus.busy, m_run);
      chk("done", bus.done, m_done);
      chk("err_rd_busy", bus.err_rd_busy, m_err);
      for (int i = 0; i < NT; i++)
         chk($sformatf("wr_count[%0d]", i),
             bus.wr_count[i*CW +: CW], m_cnt[i]);
      if (!bus.rd_valid) chk("rd_data_hold", bus.rd_data, m_last);
   endtask

   task automatic do_reset();
      idle();
      idle3();
      reset = 1'b0;
      #3;
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err_rd_busy, 0);
      chk("rst_wr_count", bus.wr_count, 0);
      m_run = 1'b0;
      m_done = 1'b0;
      m_err = 1'b0;
      m_flags = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_last = '0;
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
   endtask

   // scoreboard monitor: pop and compare on every rd_valid
   always @(negedge clk) begin
      rd_t e;
      if (reset && bus.rd_valid) begin
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL rd_unexpected: rd_valid=1 got %0h expected none",
                     bus.rd_data);
         end else begin
            e = sb.pop_front();
            chk("rd_data", bus.rd_data, e.data);
            chk("rd_latency", cyc, e.cyc);
            m_last = e.data;
         end
      end
   end

   task automatic read(input int t, input int a);
      bus.rd_req  = 1'b1;
      bus.rd_tile = TS'(t);
      bus.rd_addr = AW'(a);
   endtask

   task automatic finish_pass();
      idle();
      bus.tile_done = '1;
      tick();
      idle();
   endtask

   initial begin
      logic [DW-1:0] el;
      logic [RW-1:0] d3 [3];
      idle();
      idle3();
      do_reset();
      tick();

      // fill every bank; tile 0 writes 130 times
      bus.start = 1'b1;
      tick();
      idle();
      for (int r = 0; r < 130; r++) begin
         bus.tile_we = (r < DEPTH) ? 4'hF : 4'h1;
         for (int i = 0; i < NT; i++) begin
            bus.tile_addr[i*AW +: AW] = AW'(r % DEPTH);
            bus.tile_data[i*RW +: RW] = rnd_row();
         end
         tick();
      end
      chk("sat_cnt0", bus.wr_count[0 +: CW], DEPTH);
      finish_pass();
      chk("fill_done", bus.done, 1);

      // rows 0..7 of {tile,row}; done follows the last write
      bus.start = 1'b1;
      tick();
      idle();
      for (int r = 0; r < 8; r++) begin
         bus.tile_we = '1;
         for (int i = 0; i < NT; i++) begin
            el = {8'(i), 8'(r)};
            bus.tile_addr[i*AW +: AW] = AW'(r);
            bus.tile_data[i*RW +: RW] = {MS{el}};
         end
         tick();
      end
      finish_pass();
      chk("done_after_writes", bus.done, 1);
      chk("cnt8_tile3", bus.wr_count[3*CW +: CW], 8);
      read(2, 5);
      tick();
      idle();
      tick();
      tick();
      chk("read_2_5", bus.rd_data, {MS{16'h0205}});

      // back-to-back reads, tiles 0..3 row 0
      for (int t = 0; t < NT; t++) begin
         read(t, 0);
         tick();
      end
      idle();
      repeat (3) tick();

      // staggered tile_done, write pending on the last one
      bus.start = 1'b1;
      tick();
      idle();
      for (int t = 0; t < NT; t++) begin
         bus.tile_done = 4'(1 << t);
         if (t == NT - 1) begin
            bus.tile_we = 4'h1;
            bus.tile_addr[0 +: AW] = AW'(9);
            bus.tile_data[0 +: RW] = rnd_row();
         end
         tick();
         idle();
      end
      chk("done_delayed_by_write", bus.done, 0);
      tick();
      chk("done_after_stagger", bus.done, 1);

      // read in RUN is rejected; start clears the error
      bus.start = 1'b1;
      tick();
      idle();
      read(1, 2);
      tick();
      idle();
      chk("err_in_run", bus.err_rd_busy, 1);
      finish_pass();
      read(1, 3);
      tick();
      idle();
      bus.start = 1'b1;
      tick();
      idle();
      chk("err_cleared", bus.err_rd_busy, 0);
      tick();
      finish_pass();
      bus.start = 1'b1;
      read(0, 4);
      tick();
      idle();
      chk("start_beats_read", bus.err_rd_busy, 1);
      finish_pass();
      repeat (3) tick();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         idle();
         if (m_run) begin
            bus.tile_we   = 4'($urandom);
            bus.tile_addr = 28'($urandom);
            for (int i = 0; i < NT; i++)
               bus.tile_data[i*RW +: RW] = rnd_row();
            for (int i = 0; i < NT; i++)
               bus.tile_done[i] = ($urandom_range(0, 15) == 0);
            bus.rd_req = ($urandom_range(0, 7) == 0);
            bus.start  = ($urandom_range(0, 7) == 0);
         end else begin
            bus.rd_req = $urandom_range(0, 1);
            bus.start  = ($urandom_range(0, 9) == 0);
         end
         bus.rd_tile = TS'($urandom);
         bus.rd_addr = AW'($urandom);
         tick();
      end
      idle();
      for (int k = 0; k < 5 && m_run; k++) finish_pass();
      repeat (3) tick();

      // reset mid-RUN keeps bank contents
      bus.start = 1'b1;
      tick();
      idle();
      bus.tile_we = 4'h8;
      bus.tile_addr[3*AW +: AW] = AW'(20);
      bus.tile_data[3*RW +: RW] = rnd_row();
      tick();
      idle();
      bus.tile_we = 4'h2;
      bus.tile_addr[1*AW +: AW] = AW'(21);
      bus.tile_data[1*RW +: RW] = rnd_row();
      tick();
      @(negedge clk);
      do_reset();
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_done", bus.done, 0);
      read(3, 20);
      tick();
      idle();
      bus.start = 1'b1;
      tick();
      idle();
      finish_pass();
      read(1, 21);
      tick();
      idle();
      repeat (3) tick();

      // NUM_TILES=3: select 3 reads as zero
      bus3.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      idle3();
      bus3.tile_we = 3'h7;
      for (int i = 0; i < 3; i++) begin
         d3[i] = rnd_row();
         bus3.tile_data[i*RW +: RW] = d3[i];
      end
      @(posedge clk);
      @(negedge clk);
      idle3();
      bus3.tile_done = 3'h7;
      @(posedge clk);
      @(negedge clk);
      idle3();
      chk("t3_done", bus3.done, 1);
      bus3.rd_req  = 1'b1;
      bus3.rd_tile = 2'd2;
      @(posedge clk);
      @(negedge clk);
      bus3.rd_tile = 2'd3;
      @(posedge clk);
      @(negedge clk);
      idle3();
      chk("t3_valid_a", bus3.rd_valid, 1);
      chk("t3_tile2", bus3.rd_data, d3[2]);
      @(posedge clk);
      @(negedge clk);
      chk("t3_valid_b", bus3.rd_valid, 1);
      chk("t3_tile3_zero", bus3.rd_data, 0);
      @(posedge clk);
      @(negedge clk);
      chk("t3_idle", bus3.rd_valid, 0);

      for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL rd_drain: %0d reads outstanding, expected 0",
                  sb.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/tile_output_collector.md
TILE_OUTPUT_COLLECTOR -- requirements
Module: tile_output_collector

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter AWIDTH, default 7, bank address width; bank depth is 2^AWIDTH rows.
REQ-003 SHALL have parameter MAT_MUL_SIZE, default 4, elements per row; row width RW = MAT_MUL_SIZE*DWIDTH.
REQ-004 SHALL have parameter NUM_TILES, default 4, number of systolic tiles, one private bank each.
REQ-005 SHALL have parameter TSEL, default 2, tile-select width, with 2^TSEL >= NUM_TILES.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1; asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1, single-cycle pulse that begins a collection pass.
REQ-009 SHALL have port tile_we, input, NUM_TILES, per-tile row write strobe.
REQ-010 SHALL have port tile_addr, input, NUM_TILES*AWIDTH, per-tile row address; tile i occupies slice i.
REQ-011 SHALL have port tile_data, input, NUM_TILES*RW, per-tile row data; tile i occupies slice i.
REQ-012 SHALL have port tile_done, input, NUM_TILES, per-tile completion level.
REQ-013 SHALL have port rd_req, input, 1, host readback request.
REQ-014 SHALL have port rd_tile, input, TSEL, bank select for readback.
REQ-015 SHALL have port rd_addr, input, AWIDTH, row address for readback.
REQ-016 SHALL have port rd_valid, output, 1, one-cycle pulse marking rd_data valid.
REQ-017 SHALL have port rd_data, output, RW, readback row.
REQ-018 SHALL have port wr_count, output, NUM_TILES*(AWIDTH+1), rows written per tile in the current pass.
REQ-019 SHALL have port busy, output, 1, high in RUN.
REQ-020 SHALL have port done, output, 1, high in DONE.
REQ-021 SHALL have port err_rd_busy, output, 1, sticky flag for a rejected readback.

Function
REQ-022 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-023 SHALL, in IDLE or DONE, enter RUN on start=1, clearing wr_count, the sticky done flags and err_rd_busy on the same edge.
REQ-024 SHALL ignore start while in RUN.
REQ-025 SHALL, in RUN, write tile_data slice i into bank i at tile_addr slice i on every cycle with tile_we[i]=1; all tiles may write in the same cycle.
REQ-026 SHALL increment wr_count[i] on each accepted write, saturating at 2^AWIDTH.
REQ-027 SHALL ignore tile_we while in IDLE or DONE; bank contents and counts are then unchanged.
REQ-028 SHALL set sticky flag i in RUN whenever tile_done[i]=1; the flag holds until the next start.
REQ-029 SHALL move RUN->DONE on the first cycle in which all NUM_TILES flags (including the current cycle's tile_done) are set and tile_we is all-zero; a write pending in that cycle delays the transition by one cycle.
REQ-030 SHALL accept rd_req in IDLE or DONE; the bank is read on the next edge, and rd_valid=1 with rd_data presented on the edge after that (2-cycle latency, back-to-back requests allowed, one result per cycle).
REQ-031 SHALL return rd_data = 0 with rd_valid=1 for rd_tile >= NUM_TILES.
REQ-032 SHALL select the output bank with a registered bank select; the bank outputs SHALL NOT be OR-combined.
REQ-033 SHALL hold rd_data at its last value while rd_valid=0.
REQ-034 SHALL reject rd_req in RUN: no rd_valid pulse, and err_rd_busy is set.
REQ-035 SHALL give start priority over rd_req when both arrive in the same cycle in IDLE or DONE: the read is rejected and err_rd_busy is set after the clear.
REQ-036 SHALL still deliver a read already in the pipeline when start arrives.

Reset
REQ-037 SHALL, while reset=0, force the state to IDLE and clear rd_valid, rd_data, wr_count, busy, done, err_rd_busy, the sticky flags and the read pipeline, regardless of clock.
REQ-038 SHALL NOT clear bank contents on reset.
REQ-039 SHALL, on reset mid-RUN, discard the pass, with outputs at reset values on the next cycle.

Verification
REQ-040 SHALL pass this scenario: defaults; start; each tile writes rows 0..7 with data {tile,row} replicated; tile_done=4'b1111 -> done=1 one cycle after the last write; wr_count each = 8; read tile 2 row 5 returns {2,5} with rd_valid 2 cycles after rd_req.
REQ-041 SHALL pass this scenario: tile_done arrives 0001, 0010, 0100, 1000 in separate cycles -> done=1 only after the fourth; with tile_we=0001 in that cycle, DONE is entered one cycle later.
REQ-042 SHALL pass this scenario: rd_req in RUN -> no rd_valid and err_rd_busy=1; the next start clears it.
REQ-043 SHALL pass this scenario: 4 back-to-back rd_req for tiles 0..3, row 0 -> 4 consecutive rd_valid pulses with the matching data; rd_tile=3 with NUM_TILES=3 -> rd_data=0.
REQ-044 SHALL pass this scenario: 130 writes from tile 0 in one pass with AWIDTH=7 -> wr_count[0] saturates at 128.
REQ-045 SHALL pass this scenario: reset asserted mid-RUN, then start and read without rewriting -> busy=0 and done=0 immediately, and a read returns the earlier data.
